regfile_scan_port: RTL and testbench
====================================

REGFILE_SCAN_PORT -- requirements
Module: regfile_scan_port

Interface
REQ-001 Parameter DATA_W, default 16, register data width.
REQ-002 Parameter ADDR_W, default 4, register address width (2**ADDR_W registers).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request a scan, sampled only in IDLE.
REQ-006 mode  in  1  0 = dump (read registers out), 1 = load (write registers from stream); sampled with start.
REQ-007 first_addr / last_addr  in  ADDR_W each  inclusive scan range; sampled with start.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse at scan completion.
REQ-010 rf_read_addr  out  ADDR_W; rf_read_data  in  DATA_W  combinational register-file read port.
REQ-011 rf_write_addr  out  ADDR_W; rf_write_data  out  DATA_W; rf_write_enable  out  1  register-file write port, all registered.
REQ-012 out_valid  out  1; out_ready  in  1; out_data  out  DATA_W; out_addr  out  ADDR_W  dump stream.
REQ-013 in_valid  in  1; in_ready  out  1; in_data  in  DATA_W  load stream.

Function
REQ-014 States SHALL be IDLE, DUMP, LOAD, DONE; encoding free.
REQ-015 IDLE: start=1 -> latch range, ptr<=first_addr, remaining count N=((last_addr-first_addr) mod 2**ADDR_W)+1; go DUMP (mode 0) or LOAD (mode 1).
REQ-016 Range wraps modulo 2**ADDR_W: first=14, last=1 visits 14,15,0,1; first==last visits exactly one register.
REQ-017 ptr increments modulo 2**ADDR_W after each word; rf_read_addr SHALL equal ptr in DUMP.
REQ-018 DUMP: single output holding register; loaded with rf_read_data and ptr when empty or being accepted in the same cycle and words remain to fetch.
REQ-019 out_valid rises one cycle after start is accepted; with out_ready held high, one word per cycle, N consecutive valid cycles.
REQ-020 out_data/out_addr SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 DUMP -> DONE on the cycle the last word handshakes (out_valid&out_ready) and nothing remains to fetch.
REQ-022 LOAD: in_ready=1 for exactly N handshakes, 0 otherwise; each in_valid&in_ready registers rf_write_enable=1, rf_write_addr=ptr, rf_write_data=in_data for the next cycle.
REQ-023 rf_write_enable SHALL be 0 in any cycle not following a load handshake.
REQ-024 LOAD -> DONE on the cycle of the Nth handshake; final write is presented during DONE.
REQ-025 DONE: done=1 for one cycle, then IDLE; in_ready=0 and out_valid=0 in DONE.
REQ-026 start while busy=1 SHALL be ignored; range/mode inputs ignored outside IDLE.
REQ-027 No data loss or duplication under arbitrary out_ready / in_valid patterns.

Reset
REQ-028 reset=1 at a clock edge SHALL force IDLE, ptr=0, count=0, output holding register empty.
REQ-029 Reset values: busy=0, done=0, out_valid=0, out_data=0, out_addr=0, in_ready=0, rf_read_addr=0, rf_write_enable=0, rf_write_addr=0, rf_write_data=0.
REQ-030 reset mid-scan SHALL abort with no further rf_write_enable and no done pulse; start accepted on the first cycle after reset deasserts.

Verification
REQ-031 Registers preloaded r[i]=16'h1000+i; dump first=2,last=5, out_ready=1 -> words (2,1002),(3,1003),(4,1004),(5,1005) on 4 consecutive cycles, done on the following cycle.
REQ-032 Dump first=14,last=1 with out_ready toggling 1,0 -> addresses 14,15,0,1 in order, each held stable while stalled, exactly 4 handshakes.
REQ-033 Load first=7,last=7, in_data=16'hBEEF -> one rf write addr 7 data BEEF, in_ready low afterwards, done one cycle later; then dump 7..7 returns BEEF.
REQ-034 Load first=0,last=15 with in_valid gaps -> 16 writes r[i]=16'hA000+i, in order, no extra writes; start pulsed mid-scan ignored.
REQ-035 Dump 0..15 with reset asserted after 3 handshakes -> out_valid=0, busy=0 next cycle, no done; new dump 0..0 completes normally.

Source files
------------

// File: rtl/regfile_scan_port.sv
// rtl/regfile_scan_port.sv - register-file scan port: streams a wrapping address range out (dump) or in (load)
module regfile_scan_port #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_write_enable,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data
);

    typedef enum logic [1:0] {IDLE, DUMP, LOAD, DONE} state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W-1:0] range_span;
    logic              out_fire;
    logic              in_fire;
    logic              hold_load;

    assign range_span   = last_addr - first_addr;
    assign rf_read_addr = ptr;
    assign out_fire     = out_valid & out_ready;
    assign in_fire      = in_valid & in_ready;
    // In DUMP, count is words still to fetch; the holding register refills when empty or draining.
    assign hold_load    = (state == DUMP) && (!out_valid || out_ready) && (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            ptr             <= '0;
            count           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_addr        <= '0;
            in_ready        <= 1'b0;
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
        end else begin
            rf_write_enable <= 1'b0;
            done            <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr   <= first_addr;
                        count <= {1'b0, range_span} + CNT_ONE;
                        busy  <= 1'b1;
                        if (mode) begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end else begin
                            state <= DUMP;
                        end
                    end
                end
                DUMP: begin
                    if (hold_load) begin
                        out_valid <= 1'b1;
                        out_data  <= rf_read_data;
                        out_addr  <= ptr;
                        ptr       <= ptr + PTR_ONE;
                        count     <= count - CNT_ONE;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                    if (out_fire && count == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        rf_write_enable <= 1'b1;
                        rf_write_addr   <= ptr;
                        rf_write_data   <= in_data;
                        ptr             <= ptr + PTR_ONE;
                        count           <= count - CNT_ONE;
                        if (count == CNT_ONE) begin
                            in_ready <= 1'b0;
                            state    <= DONE;
                            done     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scan_port.sv
// tb/tb_regfile_scan_port.sv - bench for regfile_scan_port against an array-based scan model
module tb_regfile_scan_port;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          reset, start, mode, preload;
    logic [AW-1:0] first_addr, last_addr;
    logic          busy, done;
    logic [AW-1:0] rf_read_addr, rf_write_addr, out_addr;
    logic [DW-1:0] rf_read_data, rf_write_data, out_data, in_data;
    logic          rf_write_enable, out_valid, out_ready, in_valid, in_ready;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] rf_mem  [NR];
    logic [DW-1:0] ref_mem [NR];
    int act_wa[$];
    int act_wd[$];

    regfile_scan_port #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .first_addr(first_addr), .last_addr(last_addr),
        .busy(busy), .done(done),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_write_enable(rf_write_enable),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
    );

    always #5 clk = ~clk;

    assign rf_read_data = rf_mem[rf_read_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NR; i++) rf_mem[i] <= 16'h1000 + 16'(i);
        end else if (rf_write_enable) begin
            rf_mem[rf_write_addr] <= rf_write_data;
        end
    end

    always @(negedge clk) begin
        if (rf_write_enable === 1'b1) begin
            act_wa.push_back(int'(rf_write_addr));
            act_wd.push_back(int'(rf_write_data));
        end
    end

    task automatic test_reset();
        reset = 1; preload = 1; start = 0; mode = 0; first_addr = 0; last_addr = 0;
        out_ready = 0; in_valid = 0; in_data = 0;
        for (int i = 0; i < NR; i++) ref_mem[i] = 16'h1000 + 16'(i);
        repeat (3) @(negedge clk);
        preload = 0;
        total++;
        if ({busy, done, out_valid, out_data, out_addr, in_ready, rf_read_addr,
             rf_write_enable, rf_write_addr, rf_write_data} !== '0) begin
            bad++;
            $display("FAIL reset_values: busy=%b done=%b ov=%b od=%h oa=%0d ir=%b ra=%0d we=%b wa=%0d wd=%h required all zero",
                     busy, done, out_valid, out_data, out_addr, in_ready, rf_read_addr,
                     rf_write_enable, rf_write_addr, rf_write_data);
        end
        reset = 0;
        @(negedge clk);
    endtask

    // rmode: 0 ready held high, 1 ready toggles starting low, 2 random ready
    task automatic run_dump(input int first, input int last, input int rmode, input string name);
        int n = ((last - first) & 15) + 1;
        int got_a[$];
        int got_d[$];
        int dones = 0, first_v = -1, done_c = -1;
        bit timeout = 1;
        logic pv = 0, pr = 0;
        logic [AW-1:0] pa = '0;
        logic [DW-1:0] pd = '0;
        start = 1; mode = 0; first_addr = AW'(first); last_addr = AW'(last); out_ready = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = 0; mode = 1'($urandom); first_addr = AW'($urandom); last_addr = AW'($urandom);
            if (pv && !pr) begin
                total++;
                if (out_valid !== 1'b1 || out_addr !== pa || out_data !== pd) begin
                    bad++;
                    $display("FAIL %s stall_hold: valid=%b addr=%0d data=%h required valid=1 addr=%0d data=%h",
                             name, out_valid, out_addr, out_data, pa, pd);
                end
            end
            if (out_valid === 1'b1 && first_v < 0) first_v = c;
            if (done_c >= 0 && c == done_c + 1) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL %s busy_after_done: busy=%b required 0", name, busy);
                end
                timeout = 0;
                break;
            end
            if (done === 1'b1) begin
                dones++;
                if (done_c < 0) done_c = c;
                total++;
                if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL %s done_state: ov=%b ir=%b busy=%b required 0 0 1",
                             name, out_valid, in_ready, busy);
                end
            end
            case (rmode)
                0:       out_ready = 1;
                1:       out_ready = (c % 2 == 1);
                default: out_ready = 1'($urandom);
            endcase
            if (out_valid === 1'b1 && out_ready) begin
                got_a.push_back(int'(out_addr));
                got_d.push_back(int'(out_data));
            end
            pv = out_valid; pr = out_ready; pa = out_addr; pd = out_data;
        end
        out_ready = 0;
        total++;
        if (timeout) begin
            bad++;
            $display("FAIL %s timeout: done seen=%0d required completion within 400 cycles", name, dones);
        end
        total++;
        if (got_a.size() != n) begin
            bad++;
            $display("FAIL %s word_count: got=%0d required=%0d", name, got_a.size(), n);
        end
        for (int i = 0; i < got_a.size() && i < n; i++) begin
            int ea = (first + i) & 15;
            total++;
            if (got_a[i] != ea || got_d[i] != int'(ref_mem[ea])) begin
                bad++;
                $display("FAIL %s word%0d: addr=%0d data=%h required addr=%0d data=%h",
                         name, i, got_a[i], got_d[i], ea, ref_mem[ea]);
            end
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL %s done_pulses: got=%0d required=1", name, dones);
        end
        if (rmode == 0) begin
            total++;
            if (first_v != 2 || done_c != n + 2) begin
                bad++;
                $display("FAIL %s timing: first_valid_cycle=%0d done_cycle=%0d required 2 and %0d",
                         name, first_v, done_c, n + 2);
            end
        end
    endtask

    // vmode: 0 valid held high, 1 random gaps; dsel: 0 random, 1 A000+addr, 2 BEEF
    task automatic run_load(input int first, input int last, input int vmode, input int dsel,
                            input bit inject, input string name);
        int n = ((last - first) & 15) + 1;
        int exp_a[$];
        int exp_d[$];
        int hs = 0, dones = 0, hs_c = -1, done_c = -1;
        bit timeout = 1;
        act_wa.delete(); act_wd.delete();
        start = 1; mode = 1; first_addr = AW'(first); last_addr = AW'(last); in_valid = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            start = (inject && c == 4);
            mode = 1'($urandom); first_addr = AW'($urandom); last_addr = AW'($urandom);
            if (done === 1'b1) begin
                dones++;
                if (done_c < 0) done_c = c;
                total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL %s done_state: ir=%b ov=%b required 0 0", name, in_ready, out_valid);
                end
            end
            if (hs == n) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL %s ready_after_last: in_ready=%b required 0 at cycle %0d", name, in_ready, c);
                end
            end
            if (done_c >= 0 && c == done_c + 2) begin
                timeout = 0;
                break;
            end
            in_valid = (vmode == 0) ? 1'b1 : ($urandom % 3 != 0);
            case (dsel)
                1:       in_data = 16'hA000 + 16'((first + hs) & 15);
                2:       in_data = 16'hBEEF;
                default: in_data = 16'($urandom);
            endcase
            if (in_valid && in_ready === 1'b1) begin
                int a = (first + hs) & 15;
                exp_a.push_back(a);
                exp_d.push_back(int'(in_data));
                ref_mem[a] = in_data;
                hs++;
                if (hs == n) hs_c = c;
            end
        end
        start = 0; in_valid = 0;
        total++;
        if (timeout) begin
            bad++;
            $display("FAIL %s timeout: handshakes=%0d required %0d and done", name, hs, n);
        end
        total++;
        if (act_wa.size() != exp_a.size()) begin
            bad++;
            $display("FAIL %s write_count: got=%0d required=%0d", name, act_wa.size(), exp_a.size());
        end
        for (int i = 0; i < act_wa.size() && i < exp_a.size(); i++) begin
            total++;
            if (act_wa[i] != exp_a[i] || act_wd[i] != exp_d[i]) begin
                bad++;
                $display("FAIL %s write%0d: addr=%0d data=%h required addr=%0d data=%h",
                         name, i, act_wa[i], act_wd[i], exp_a[i], exp_d[i]);
            end
        end
        total++;
        if (dones != 1 || done_c != hs_c + 1) begin
            bad++;
            $display("FAIL %s done_timing: pulses=%0d done_cycle=%0d required 1 pulse at cycle %0d",
                     name, dones, done_c, hs_c + 1);
        end
    endtask

    task automatic test_reset_midscan();
        int hs = 0;
        bit fired = 0;
        act_wa.delete(); act_wd.delete();
        start = 1; mode = 0; first_addr = 0; last_addr = 15; out_ready = 1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            start = 0;
            if (hs == 3) begin
                fired = 1;
                break;
            end
            if (out_valid === 1'b1) hs++;
        end
        total++;
        if (!fired) begin
            bad++;
            $display("FAIL midscan_handshakes: got=%0d required 3 within 50 cycles", hs);
        end
        reset = 1; out_ready = 0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rf_write_enable !== 1'b0) begin
            bad++;
            $display("FAIL midscan_abort: ov=%b busy=%b done=%b we=%b required all 0",
                     out_valid, busy, done, rf_write_enable);
        end
        reset = 0;
        run_dump(0, 0, 0, "after_reset");
        total++;
        if (act_wa.size() != 0) begin
            bad++;
            $display("FAIL midscan_writes: got=%0d required=0", act_wa.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            int f = int'($urandom % 16);
            int l = int'($urandom % 16);
            if ($urandom % 2 == 1) run_load(f, l, 1, 0, 1'($urandom), "rand_load");
            else                   run_dump(f, l, 2, "rand_dump");
            repeat ($urandom % 3) @(negedge clk);
        end
        run_dump(0, 15, 2, "rand_full_dump");
    endtask

    initial begin
        test_reset();
        run_dump(2, 5, 0, "dump_2_5");
        run_dump(14, 1, 1, "dump_wrap_stall");
        run_load(7, 7, 0, 2, 0, "load_7");
        run_dump(7, 7, 0, "dump_7");
        run_load(0, 15, 1, 1, 1, "load_full");
        run_dump(0, 15, 2, "dump_full");
        test_reset_midscan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
